// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and sizes for the instruction-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_TURN  = 2'd2
    } arb_state_t;

    localparam int IMEM_ADDR_BITS = 6;
    localparam int IMEM_DATA_W    = 32;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Fetch, loader and RAM-side signals of the instruction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_BITS = IMEM_ADDR_BITS,
    parameter int DATA_W    = IMEM_DATA_W
);
    logic                 fetch_req;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic                 fetch_stall;
    logic                 fetch_rvalid;
    logic [DATA_W-1:0]    fetch_rdata;

    logic                 loader_valid;
    logic [ADDR_BITS-1:0] loader_addr;
    logic [DATA_W-1:0]    loader_wdata;
    logic                 loader_ready;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, loader_valid, loader_addr, loader_wdata, mem_rdata,
        output fetch_stall, fetch_rvalid, fetch_rdata, loader_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, loader_valid, loader_addr, loader_wdata, mem_rdata,
        input  fetch_stall, fetch_rvalid, fetch_rdata, loader_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_sat_counter
// Description : Up-counter that sticks at MAX_COUNT; clear has priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
    parameter int MAX_COUNT = 4,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_clear,
    input  wire logic             i_incr,
    output logic      [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares the single-port instruction RAM between fetch reads
//               and loader write bursts, with a starvation bound on both.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_BITS    = IMEM_ADDR_BITS,
    parameter int DATA_W       = IMEM_DATA_W,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic     clock,
    input  wire logic     reset,
    imem_arbiter_if.slave bus
);
    localparam int c_WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX   = c_WAIT_W'(STARVE_LIMIT);
    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(MAX_BURST - 1);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [c_WAIT_W-1:0]  w_wait_cnt;
    logic [c_BURST_W-1:0] w_burst_cnt;
    logic                 w_wait_clr;
    logic                 w_wait_inc;
    logic                 w_burst_clr;
    logic                 w_burst_inc;
    logic                 w_do_write;
    logic                 w_fetch_read;
    logic                 w_loader_ready;
    logic                 w_fetch_stall;
    logic                 w_mem_en;
    logic                 w_mem_we;
    logic [ADDR_BITS-1:0] w_mem_addr;
    logic [DATA_W-1:0]    w_mem_wdata;
    logic                 r_fetch_rvalid;

    arb_sat_counter #(
        .MAX_COUNT (STARVE_LIMIT),
        .WIDTH     (c_WAIT_W)
    ) u_wait_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_wait_clr),
        .i_incr  (w_wait_inc),
        .o_count (w_wait_cnt)
    );

    arb_sat_counter #(
        .MAX_COUNT (MAX_BURST),
        .WIDTH     (c_BURST_W)
    ) u_burst_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_burst_clr),
        .i_incr  (w_burst_inc),
        .o_count (w_burst_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_FETCH;
            r_fetch_rvalid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_fetch_rvalid <= w_fetch_read;
        end
    end

    // Outputs stay quiet while reset is held, even though state is already S_FETCH.
    always_comb begin
        w_next_state   = r_state;
        w_wait_clr     = 1'b0;
        w_wait_inc     = 1'b0;
        w_burst_clr    = 1'b0;
        w_burst_inc    = 1'b0;
        w_do_write     = 1'b0;
        w_fetch_read   = 1'b0;
        w_loader_ready = 1'b0;
        w_fetch_stall  = 1'b0;
        w_mem_en       = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr     = '0;
        w_mem_wdata    = '0;
        if (reset) begin
            unique case (r_state)
                S_FETCH: begin
                    if (bus.loader_valid && (!bus.fetch_req || (w_wait_cnt == c_WAIT_MAX))) begin
                        w_do_write    = 1'b1;
                        w_fetch_stall = bus.fetch_req;
                        w_wait_clr    = 1'b1;
                        w_burst_inc   = 1'b1;
                        w_next_state  = (MAX_BURST == 1) ? S_TURN : S_LOAD;
                    end else begin
                        w_mem_en     = bus.fetch_req;
                        w_mem_addr   = bus.fetch_addr;
                        w_fetch_read = bus.fetch_req;
                        w_wait_inc   = bus.loader_valid && bus.fetch_req;
                        w_wait_clr   = !(bus.loader_valid && bus.fetch_req);
                    end
                end
                S_LOAD: begin
                    w_fetch_stall = bus.fetch_req;
                    if (bus.loader_valid) begin
                        w_do_write  = 1'b1;
                        w_burst_inc = 1'b1;
                        if (w_burst_cnt == c_BURST_LAST) begin
                            w_next_state = S_TURN;
                        end
                    end else begin
                        w_next_state = S_TURN;
                    end
                end
                S_TURN: begin
                    // Dead cycle after a write so a read never follows it directly.
                    w_fetch_stall = bus.fetch_req;
                    w_burst_clr   = 1'b1;
                    w_next_state  = S_FETCH;
                end
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
            if (w_do_write) begin
                w_loader_ready = 1'b1;
                w_mem_en       = 1'b1;
                w_mem_we       = 1'b1;
                w_mem_addr     = bus.loader_addr;
                w_mem_wdata    = bus.loader_wdata;
            end
        end
    end

    assign bus.loader_ready = w_loader_ready;
    assign bus.fetch_stall  = w_fetch_stall;
    assign bus.mem_en       = w_mem_en;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.fetch_rvalid = r_fetch_rvalid;
    assign bus.fetch_rdata  = r_fetch_rvalid ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Directed bench for imem_arbiter with a cycle-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int AW     = 6;
    localparam int DW     = 32;
    localparam int MAXB   = 8;
    localparam int STARVE = 4;

    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic preload = 1'b1;
    always #5 clock = ~clock;

    imem_arbiter_if #(.ADDR_BITS(AW), .DATA_W(DW)) ifc  ();
    imem_arbiter_if #(.ADDR_BITS(AW), .DATA_W(DW)) ifc1 ();

    imem_arbiter #(.ADDR_BITS(AW), .DATA_W(DW), .MAX_BURST(MAXB), .STARVE_LIMIT(STARVE))
        dut (.clock(clock), .reset(reset), .bus(ifc));
    imem_arbiter #(.ADDR_BITS(AW), .DATA_W(DW), .MAX_BURST(1), .STARVE_LIMIT(STARVE))
        dut1 (.clock(clock), .reset(reset), .bus(ifc1));

    // Instruction RAM: write-first across cycles, one-cycle read latency.
    logic [DW-1:0] ram [64];
    logic [DW-1:0] ram_q;
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= (i == 3) ? 32'h8C09_0000 : '0;
            ram_q <= '0;
        end else if (ifc.mem_en) begin
            if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
            else            ram_q <= ram[ifc.mem_addr];
        end
    end
    assign ifc.mem_rdata  = ram_q;
    assign ifc1.mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: phase 0 = fetch priority, 1 = inside a write burst, 2 = turnaround.
    int            m_phase, m_wait, m_writes;
    logic          m_rv;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] shadow [64];
    int            n_phase, n_wait, n_writes;
    logic          n_commit, n_we, n_read;
    logic [AW-1:0] n_waddr, n_raddr;
    logic [DW-1:0] n_wdata;

    always @(negedge clock) begin : model_cmp
        logic          g, e_ready, e_en, e_we, e_stall;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        e_ready = 0; e_en = 0; e_we = 0; e_stall = 0; e_addr = '0; e_wdata = '0; g = 0;
        n_commit = 0; n_we = 0; n_read = 0;
        n_phase = m_phase; n_wait = m_wait; n_writes = m_writes;
        n_waddr = ifc.loader_addr; n_wdata = ifc.loader_wdata; n_raddr = ifc.fetch_addr;
        if (reset) begin
            n_commit = 1;
            if (m_phase == 0) begin
                g = ifc.loader_valid && (!ifc.fetch_req || m_wait >= STARVE);
                if (g) begin
                    e_we = 1; e_stall = ifc.fetch_req;
                    n_wait = 0; n_writes = 1; n_phase = (MAXB == 1) ? 2 : 1;
                end else begin
                    e_en = ifc.fetch_req; e_addr = ifc.fetch_addr; n_read = ifc.fetch_req;
                    n_wait = (ifc.loader_valid && ifc.fetch_req) ?
                             ((m_wait + 1 > STARVE) ? STARVE : m_wait + 1) : 0;
                end
            end else if (m_phase == 1) begin
                e_stall = ifc.fetch_req;
                if (ifc.loader_valid) begin
                    e_we = 1; n_writes = m_writes + 1;
                    n_phase = (n_writes >= MAXB) ? 2 : 1;
                end else begin
                    n_phase = 2;
                end
            end else begin
                e_stall = ifc.fetch_req; n_phase = 0; n_writes = 0;
            end
            if (e_we) begin
                e_ready = 1; e_en = 1; e_addr = ifc.loader_addr; e_wdata = ifc.loader_wdata;
                n_we = 1;
            end
        end
        chk("loader_ready", 32'(ifc.loader_ready), 32'(e_ready));
        chk("mem_en", 32'(ifc.mem_en), 32'(e_en));
        chk("mem_we", 32'(ifc.mem_we), 32'(e_we));
        chk("fetch_stall", 32'(ifc.fetch_stall), 32'(e_stall));
        chk("fetch_rvalid", 32'(ifc.fetch_rvalid), (reset && m_rv) ? 32'd1 : 32'd0);
        chk("fetch_rdata", ifc.fetch_rdata, (reset && m_rv) ? m_rd : '0);
        if (e_en || !reset) chk("mem_addr", 32'(ifc.mem_addr), 32'(e_addr));
        if (e_we || !reset) chk("mem_wdata", ifc.mem_wdata, e_wdata);
    end

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) shadow[i] <= (i == 3) ? 32'h8C09_0000 : '0;
        end else if (reset && n_commit && n_we) begin
            shadow[n_waddr] <= n_wdata;
        end
        if (!reset) begin
            m_phase <= 0; m_wait <= 0; m_writes <= 0; m_rv <= 1'b0; m_rd <= '0;
        end else if (n_commit) begin
            m_phase <= n_phase; m_wait <= n_wait; m_writes <= n_writes;
            m_rv    <= n_read;
            if (n_read) m_rd <= shadow[n_raddr];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        ifc.fetch_req = 0; ifc.loader_valid = 0;
        repeat (n) step();
    endtask

    task automatic fetch_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                              output int stalls);
        ifc.fetch_req = 1; ifc.fetch_addr = addr; stalls = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (!ifc.fetch_stall) break;
            stalls++;
            step();
        end
        chk("fetch_wait_bound", 32'(stalls <= MAXB + 1), 32'd1);
        step();
        ifc.fetch_req = 0;
        @(negedge clock);
        chk("read_rvalid", 32'(ifc.fetch_rvalid), 32'd1);
        data = ifc.fetch_rdata;
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] d;
        int            st, nacc, c_last, rdy_cnt, stall_cnt;
        ifc.fetch_req = 0; ifc.fetch_addr = '0; ifc.loader_valid = 0;
        ifc.loader_addr = '0; ifc.loader_wdata = '0;
        ifc1.fetch_req = 1; ifc1.fetch_addr = 6'd2; ifc1.loader_valid = 1;
        ifc1.loader_addr = 6'd9; ifc1.loader_wdata = 32'h1234_5678;
        repeat (3) @(posedge clock);
        #1;
        preload = 0; reset = 1;
        idle(2);

        // Fetch-only stream, then the preloaded word.
        for (int a = 0; a < 4; a++) begin
            ifc.fetch_req = 1; ifc.fetch_addr = AW'(a);
            @(negedge clock);
            chk($sformatf("fetch_only_stall_%0d", a), 32'(ifc.fetch_stall), 32'd0);
            step();
        end
        ifc.fetch_req = 0;
        @(negedge clock);
        chk("preload_word3", ifc.fetch_rdata, 32'h8C09_0000);
        idle(2);

        // Loader only: three writes 10..12.
        ifc.loader_valid = 1; ifc.loader_addr = 6'd10; ifc.loader_wdata = 32'hA0;
        nacc = 0; c_last = -1;
        for (int c = 0; c < 10 && nacc < 3; c++) begin
            @(negedge clock);
            if (ifc.loader_ready) nacc++;
            c_last = c;
            step();
            ifc.loader_addr = AW'(10 + nacc); ifc.loader_wdata = DW'(32'hA0 + nacc);
            if (nacc == 3) ifc.loader_valid = 0;
        end
        chk("loader_three_consecutive", 32'(c_last), 32'd2);
        @(negedge clock);
        chk("loader_done_ready", 32'(ifc.loader_ready), 32'd0);
        idle(3);
        fetch_read(6'd11, d, st);
        chk("readback_11", d, 32'hA1);
        idle(2);

        // Sustained contention: 4 refusals, 8 writes, 1 turnaround, repeat.
        ifc.fetch_req = 1; ifc.fetch_addr = 6'd1;
        ifc.loader_valid = 1; ifc.loader_addr = 6'd20; ifc.loader_wdata = 32'hC0DE_0000;
        nacc = 0; rdy_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clock);
            chk($sformatf("contend_ready_%0d", i), 32'(ifc.loader_ready),
                32'((i % 13) >= 4 && (i % 13) <= 11));
            chk($sformatf("contend_stall_%0d", i), 32'(ifc.fetch_stall), 32'((i % 13) >= 4));
            if (ifc.loader_ready) nacc++;
            rdy_cnt   += int'(ifc.loader_ready);
            stall_cnt += int'(ifc.fetch_stall);
            step();
            ifc.loader_addr = AW'(20 + nacc % 8); ifc.loader_wdata = DW'(32'hC0DE_0000 + nacc);
        end
        chk("contend_total_writes", 32'(rdy_cnt), 32'd16);
        chk("contend_total_stalls", 32'(stall_cnt), 32'd18);
        idle(2);
        fetch_read(6'd22, d, st);
        chk("readback_22", d, 32'hC0DE_000A);
        idle(2);

        // Loader drops after two writes with fetch waiting.
        ifc.loader_valid = 1; ifc.loader_addr = 6'd30; ifc.loader_wdata = 32'hD0;
        @(negedge clock); chk("drop_w1_ready", 32'(ifc.loader_ready), 32'd1);
        step(); ifc.loader_addr = 6'd31; ifc.loader_wdata = 32'hD1;
        @(negedge clock); chk("drop_w2_ready", 32'(ifc.loader_ready), 32'd1);
        step(); ifc.loader_valid = 0; ifc.fetch_req = 1; ifc.fetch_addr = 6'd31;
        @(negedge clock); chk("drop_stall_a", 32'(ifc.fetch_stall), 32'd1);
        step();
        @(negedge clock); chk("drop_stall_turn", 32'(ifc.fetch_stall), 32'd1);
        chk("drop_turn_no_access", 32'(ifc.mem_en), 32'd0);
        step();
        @(negedge clock); chk("drop_resume_stall", 32'(ifc.fetch_stall), 32'd0);
        step(); ifc.fetch_req = 0;
        @(negedge clock); chk("drop_readback_31", ifc.fetch_rdata, 32'hD1);
        idle(2);

        // Reset in the middle of a burst, after three writes.
        ifc.loader_valid = 1;
        for (int k = 0; k < 3; k++) begin
            ifc.loader_addr = AW'(40 + k); ifc.loader_wdata = DW'(32'hE0 + k);
            @(negedge clock);
            chk($sformatf("rst_burst_ready_%0d", k), 32'(ifc.loader_ready), 32'd1);
            step();
        end
        reset = 0; ifc.loader_valid = 0;
        @(negedge clock);
        chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
        chk("rst_loader_ready", 32'(ifc.loader_ready), 32'd0);
        chk("rst_fetch_rvalid", 32'(ifc.fetch_rvalid), 32'd0);
        step(); reset = 1;
        fetch_read(6'd5, d, st);
        chk("post_rst_no_stall", 32'(st), 32'd0);
        chk("post_rst_data", d, 32'h0);
        fetch_read(6'd41, d, st);
        chk("pre_rst_write_kept", d, 32'hE1);

        // Single-write bursts on the MAX_BURST=1 instance.
        reset = 0; step(); reset = 1;
        rdy_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            chk($sformatf("mb1_ready_%0d", i), 32'(ifc1.loader_ready), 32'((i % 6) == 4));
            chk($sformatf("mb1_en_%0d", i), 32'(ifc1.mem_en), 32'((i % 6) != 5));
            chk($sformatf("mb1_stall_%0d", i), 32'(ifc1.fetch_stall), 32'((i % 6) >= 4));
            rdy_cnt += int'(ifc1.loader_ready);
        end
        chk("mb1_total_writes", 32'(rdy_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
